// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and baud divider helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DEFAULT_BAUD       = 115200;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Rounded clocks-per-sample-tick divider.
  function automatic int uart_div(input int clk_hz, input int baud, input int oversample);
    int step;
    step = baud * oversample;
    return (clk_hz + step / 2) / step;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a one-cycle oversample tick
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - oversampling 8N1 UART receiver with valid/ready output and sticky errors
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clear,
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF_S = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_S = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

  logic                 tick;
  logic                 sync1, sync2;
  logic [1:0]           hist;
  logic                 line_now, line_q;
  logic [1:0]           fill;
  logic                 armed;
  rx_state_t            state, state_n;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 brk;
  logic                 scnt_clr, scnt_inc, shift_en, bcnt_clr, bcnt_inc;
  logic                 load, ferr_set, brk_set, brk_clr;
  logic                 xfer, ovr_set;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .tick     (tick)
  );

  // Majority of the two previous samples and the current synchronized one.
  assign line_now = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist   <= 2'b11;
      line_q <= 1'b1;
      fill   <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      if (tick) begin
        hist   <= {hist[0], sync2};
        line_q <= line_now;
        if (fill != 2'd3) fill <= fill + 2'd1;
        // Only accept start edges once real idle has been seen after reset.
        if (fill == 2'd3 && line_now) armed <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    scnt_clr = 1'b0;
    scnt_inc = 1'b0;
    shift_en = 1'b0;
    bcnt_clr = 1'b0;
    bcnt_inc = 1'b0;
    load     = 1'b0;
    ferr_set = 1'b0;
    brk_set  = 1'b0;
    brk_clr  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (armed && line_q && !line_now) begin
            state_n  = START;
            scnt_clr = 1'b1;
          end
        end
        START: begin
          if (scnt == HALF_S) begin
            scnt_clr = 1'b1;
            if (!line_now) begin
              state_n  = DATA;
              bcnt_clr = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
        DATA: begin
          if (scnt == LAST_S) begin
            scnt_clr = 1'b1;
            shift_en = 1'b1;
            if (bcnt == LAST_B) begin
              state_n  = STOP;
              bcnt_clr = 1'b1;
            end else begin
              bcnt_inc = 1'b1;
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
        STOP: begin
          if (brk) begin
            if (line_now) begin
              state_n = IDLE;
              brk_clr = 1'b1;
            end
          end else if (scnt == LAST_S) begin
            scnt_clr = 1'b1;
            if (line_now) begin
              load    = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_set = 1'b1;
              brk_set  = 1'b1;
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign xfer    = rx_valid && rx_ready;
  assign ovr_set = load && rx_valid && !xfer;
  assign busy    = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      scnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      brk         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_n;
      if (scnt_clr)      scnt <= '0;
      else if (scnt_inc) scnt <= scnt + 1'b1;
      if (bcnt_clr)      bcnt <= '0;
      else if (bcnt_inc) bcnt <= bcnt + 1'b1;
      if (shift_en) shreg <= {line_now, shreg[DATA_BITS-1:1]};
      if (brk_set)      brk <= 1'b1;
      else if (brk_clr) brk <= 1'b0;
      if (load && (!rx_valid || xfer)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end
      if (ferr_set)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (ovr_set)        overrun_err <= 1'b1;
      else if (err_clear) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - scoreboard bench for uart_rx_frontend
module tb_uart_rx_frontend;

  localparam int BIT = 432;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         lat = 0;
  bit         lat_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_d;
  int         pers[3] = '{432, 419, 445};

  uart_rx_frontend dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input int per);
    @(negedge CLOCK_50);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (per) @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (per) @(negedge CLOCK_50);
    end
    rxd = stop;
    repeat (per * stop_len) @(negedge CLOCK_50);
    rxd = 1'b1;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge CLOCK_50);
    err_clear = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Output monitor: latency of each rx_valid rise and data of each transfer.
  always @(negedge CLOCK_50) begin
    #2;
    if (rx_valid && !prev_valid && lat_en) begin
      lat = cyc - start_cyc;
      chk("latency_window", 32'(lat >= 4044 && lat <= 4164), 32'd1);
      if (!(lat >= 4044 && lat <= 4164)) $display("  latency was %0d clocks", lat);
    end
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, rx_data}, 32'h100);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  initial begin
    #(150_000 * 20);
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge CLOCK_50);
    reset_n = 1'b1;
    idle(5000);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun_err", overrun_err, 0);

    lat_en = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1, BIT);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, 1, BIT);
    idle(BIT);
    lat_en = 1'b0;
    chk("b2b_frame_err", frame_err, 0);
    chk("b2b_overrun_err", overrun_err, 0);

    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1, BIT);
    send_frame(8'hC3, 1'b1, 1, BIT);
    idle(BIT);
    chk("ovr_rx_data_held", rx_data, 8'h3C);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_flag_set", overrun_err, 1);
    rx_ready = 1'b1;
    idle(4);
    chk("ovr_drained_valid", rx_valid, 0);
    chk("ovr_flag_sticky", overrun_err, 1);
    pulse_clear();
    chk("ovr_flag_cleared", overrun_err, 0);

    send_frame(8'h5A, 1'b0, 4, BIT);
    idle(BIT);
    chk("break_frame_err", frame_err, 1);
    chk("break_no_byte", rx_valid, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1, BIT);
    idle(BIT);
    chk("break_frame_err_sticky", frame_err, 1);
    pulse_clear();
    chk("break_frame_err_cleared", frame_err, 0);

    rxd = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    rxd = 1'b1;
    repeat (50) @(negedge CLOCK_50);
    chk("glitch_busy_during", busy, 1);
    repeat (1000) @(negedge CLOCK_50);
    chk("glitch_busy_after", busy, 0);
    chk("glitch_no_valid", rx_valid, 0);
    chk("glitch_frame_err", frame_err, 0);
    chk("glitch_overrun_err", overrun_err, 0);

    frame_d = 8'h81;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      rxd = 1'b0;
      repeat (pers[k]) @(negedge CLOCK_50);
      for (int i = 0; i < 4; i++) begin
        rxd = frame_d[i];
        repeat (pers[k]) @(negedge CLOCK_50);
      end
      rxd = frame_d[4];
      repeat (pers[k] / 2) @(negedge CLOCK_50);
      reset_n = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      chk("midreset_rx_valid", rx_valid, 0);
      chk("midreset_rx_data", rx_data, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_frame_err", frame_err, 0);
      chk("midreset_overrun_err", overrun_err, 0);
      reset_n = 1'b1;
      repeat (pers[k] - pers[k] / 2 - 10) @(negedge CLOCK_50);
      for (int i = 5; i < 8; i++) begin
        rxd = frame_d[i];
        repeat (pers[k]) @(negedge CLOCK_50);
      end
      idle(2 * pers[k]);
      chk("midreset_no_partial", rx_valid, 0);
      exp_q.push_back(frame_d);
      send_frame(frame_d, 1'b1, 1, pers[k]);
      idle(pers[k]);
      chk("baud_frame_err", frame_err, 0);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
